i2s_rx_master: RTL and testbench

I2S receive master controller. It generates SCK and WS from the system clock, samples SD, and assembles left/right words. Each completed stereo frame is presented on a valid/ready handshake for downstream synthesis and DSP logic. It replaces free-running external SCK/WS with a clk-domain sequencer, so the rest of the design sees only synchronous samples.

---
 rtl/i2s_rx_master.sv | 103 ++++++++++
 tb/tb_i2s_rx_master.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_master.sv
// rtl/i2s_rx_master.sv - I2S receive master: SCK/WS generation, SD capture, stereo frame handshake
// The bit counter sits at 2*WIDTH-1 while idle so the first fall wraps it to bit 0 of a fresh frame.
module i2s_rx_master #(
  parameter int WIDTH = 32,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sd,
  output logic             sck,
  output logic             ws,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             overrun
);

  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(2 * WIDTH);
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(2 * WIDTH - 1);
  localparam logic [BW-1:0] LEFT_LAST  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] WS_HI_LAST = BW'(2 * WIDTH - 2);

  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_next;
  logic             started;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] left_hold;
  logic             tick;
  logic             rise;
  logic             fall;
  logic             frame_done;

  always_comb begin
    tick       = enable && (div_cnt == DIV_LAST);
    rise       = tick && !sck;
    fall       = tick && sck;
    bit_next   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    shift_next = {shift_reg[WIDTH-2:0], sd};
    frame_done = rise && started && (bit_cnt == BIT_LAST);
  end

  // Sequencer: divider, SCK/WS generation and serial capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      bit_cnt   <= BIT_LAST;
      started   <= 1'b0;
      sck       <= 1'b0;
      ws        <= 1'b0;
      shift_reg <= '0;
      left_hold <= '0;
      overrun   <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bit_cnt <= BIT_LAST;
      started <= 1'b0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      overrun <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        sck <= ~sck;
      end
      if (fall) begin
        bit_cnt <= bit_next;
        started <= 1'b1;
        ws      <= (bit_next >= LEFT_LAST) && (bit_next <= WS_HI_LAST);
      end
      if (rise && started) begin
        shift_reg <= shift_next;
        if (bit_cnt == LEFT_LAST) begin
          left_hold <= shift_next;
        end
      end
      if (frame_done && frame_valid && !frame_ready) begin
        overrun <= 1'b1;
      end
    end
  end

  // Output holding registers; newest frame always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_data   <= '0;
      right_data  <= '0;
      frame_valid <= 1'b0;
    end else if (frame_done) begin
      left_data   <= left_hold;
      right_data  <= shift_next;
      frame_valid <= 1'b1;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_master.sv
// tb/tb_i2s_rx_master.sv - self-checking bench for i2s_rx_master
// Expected timing comes from the closed-form edge formulas; data from a codec bit queue.
module tb_i2s_rx_master;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int C0 = 3 * D - 1 + 2 * D * (2 * W - 1);
  localparam int FP = 4 * D * W;
  localparam int W2 = 32;
  localparam int D2 = 4;
  localparam int C2 = 3 * D2 - 1 + 2 * D2 * (2 * W2 - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          sd = 1'b0;
  logic          frame_ready = 1'b1;
  logic          sck, ws, frame_valid, overrun;
  logic [W-1:0]  left_data, right_data;

  logic          enable2 = 1'b0;
  logic          sd2 = 1'b0;
  logic          ready2 = 1'b1;
  logic          sck2, ws2, fv2, ovr2;
  logic [W2-1:0] left2, right2;

  int total = 0;
  int bad = 0;

  i2s_rx_master #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sd(sd), .sck(sck), .ws(ws),
    .left_data(left_data), .right_data(right_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .overrun(overrun)
  );

  i2s_rx_master #(.WIDTH(W2), .DIV(D2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .sd(sd2), .sck(sck2), .ws(ws2),
    .left_data(left2), .right_data(right2), .frame_valid(fv2),
    .frame_ready(ready2), .overrun(ovr2)
  );

  always #5 clk = ~clk;

  // Codec models: present the next queued bit after every SCK fall.
  bit bits[$];
  bit bits2[$];
  always @(negedge sck) begin
    if (bits.size() > 0) sd = bits.pop_front();
    else sd = 1'($urandom);
  end
  always @(negedge sck2) begin
    if (bits2.size() > 0) sd2 = bits2.pop_front();
    else sd2 = 1'($urandom);
  end

  int           e = -1;
  bit           m_fv, m_ovr, x_sck, x_ws;
  logic [W-1:0] m_l = '0;
  logic [W-1:0] m_r = '0;
  logic [2*W-1:0] frames[$];

  task automatic load_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    frames.push_back({l, r});
    for (int i = W - 1; i >= 0; i--) bits.push_back(l[i]);
    for (int i = W - 1; i >= 0; i--) bits.push_back(r[i]);
  endtask

  task automatic model_step(input bit en, input bit rdy);
    int bc;
    logic [2*W-1:0] f;
    if (!en) begin
      e = -1; x_sck = 0; x_ws = 0; m_ovr = 0;
      if (m_fv && rdy) m_fv = 0;
    end else begin
      e++;
      x_sck = (e >= D - 1) && (((e - (D - 1)) % (2 * D)) < D);
      if (e < 2 * D - 1) x_ws = 0;
      else begin
        bc = ((e - (2 * D - 1)) / (2 * D)) % (2 * W);
        x_ws = (bc >= W - 1) && (bc <= 2 * W - 2);
      end
      if (e >= C0 && ((e - C0) % FP) == 0) begin
        if (m_fv && !rdy) m_ovr = 1;
        m_fv = 1;
        if (frames.size() > 0) begin
          f = frames.pop_front();
          m_l = f[2*W-1:W];
          m_r = f[W-1:0];
        end
      end else if (m_fv && rdy) m_fv = 0;
    end
  endtask

  task automatic step();
    bit en_s, rdy_s;
    en_s = enable;
    rdy_s = frame_ready;
    @(posedge clk);
    model_step(en_s, rdy_s);
    #1;
  endtask

  task automatic go_idle();
    enable = 0;
    frame_ready = 1;
    repeat (3) step();
    bits.delete();
    frames.delete();
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({sck, ws, frame_valid, overrun, left_data, right_data, sck2, ws2, fv2, ovr2, left2, right2} !== '0) begin
      bad++;
      $display("FAIL reset_assert: got %b%b%b%b %h %h, want all zero", sck, ws, frame_valid, overrun, left_data, right_data);
    end
    rst_n = 1;
    for (int n = 0; n < 20; n++) begin
      step();
      total++;
      if ({sck, ws, frame_valid, overrun, left_data, right_data, sck2, ws2, fv2} !== '0) begin
        bad++;
        $display("FAIL reset_idle edge %0d: got sck=%b ws=%b fv=%b l=%h r=%h, want zeros", n, sck, ws, frame_valid, left_data, right_data);
      end
    end
  endtask

  task automatic test_basic();
    go_idle();
    load_frame(8'hA5, 8'h3C);
    enable = 1;
    for (int n = 0; n <= C0 + 4; n++) begin
      step();
      total++;
      if ({sck, ws, frame_valid, overrun, left_data, right_data} !== {x_sck, x_ws, m_fv, m_ovr, m_l, m_r}) begin
        bad++;
        $display("FAIL basic edge %0d: got %b%b%b%b %h %h want %b%b%b%b %h %h", n, sck, ws, frame_valid, overrun,
                 left_data, right_data, x_sck, x_ws, m_fv, m_ovr, m_l, m_r);
      end
      if ((n == 1 && sck !== 1'b1) || (n == 3 && sck !== 1'b0)) begin
        bad++;
        $display("FAIL basic_sck edge %0d: got %b", n, sck);
      end
      if ((n == 30 && ws !== 1'b0) || (n == 31 && ws !== 1'b1) || (n == 62 && ws !== 1'b1) || (n == 63 && ws !== 1'b0)) begin
        bad++;
        $display("FAIL basic_ws edge %0d: got %b", n, ws);
      end
      if ((n == 64 && frame_valid !== 1'b0) || (n == 66 && frame_valid !== 1'b0) ||
          (n == 65 && {frame_valid, left_data, right_data} !== {1'b1, 8'hA5, 8'h3C})) begin
        bad++;
        $display("FAIL basic_frame edge %0d: got fv=%b l=%h r=%h", n, frame_valid, left_data, right_data);
      end
    end
  endtask

  task automatic test_backpressure();
    go_idle();
    load_frame(8'h11, 8'h22);
    load_frame(8'h33, 8'h44);
    frame_ready = 0;
    enable = 1;
    repeat (C0 + FP + 1) step();
    total++;
    if ({frame_valid, overrun, left_data, right_data} !== {1'b1, 1'b1, 8'h33, 8'h44}) begin
      bad++;
      $display("FAIL backpressure_hold: got fv=%b ovr=%b l=%h r=%h want 1 1 33 44", frame_valid, overrun, left_data, right_data);
    end
    frame_ready = 1;
    step();
    total++;
    if ({frame_valid, overrun} !== 2'b01) begin
      bad++;
      $display("FAIL backpressure_accept: got fv=%b ovr=%b want 0 1", frame_valid, overrun);
    end
    repeat (5) step();
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_sticky: got ovr=%b want 1", overrun);
    end
    enable = 0;
    step();
    total++;
    if ({overrun, sck, ws} !== 3'b000) begin
      bad++;
      $display("FAIL backpressure_clear: got ovr=%b sck=%b ws=%b want 000", overrun, sck, ws);
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] l1, r1;
    go_idle();
    l1 = W'($urandom);
    r1 = W'($urandom);
    load_frame(W'($urandom), W'($urandom));
    load_frame(l1, r1);
    frame_ready = 0;
    enable = 1;
    repeat (C0 + FP) step();
    frame_ready = 1;
    step();
    frame_ready = 0;
    total++;
    if ({frame_valid, overrun, left_data, right_data} !== {1'b1, 1'b0, l1, r1}) begin
      bad++;
      $display("FAIL simultaneous: got fv=%b ovr=%b l=%h r=%h want 1 0 %h %h", frame_valid, overrun, left_data, right_data, l1, r1);
    end
    frame_ready = 1;
    step();
  endtask

  task automatic test_abort();
    go_idle();
    load_frame(8'h5A, 8'hC3);
    enable = 1;
    repeat (3 * D + 2 * D * 4) step();
    enable = 0;
    step();
    total++;
    if ({sck, ws} !== 2'b00) begin
      bad++;
      $display("FAIL abort_stop: got sck=%b ws=%b want 00", sck, ws);
    end
    for (int n = 0; n < 10; n++) begin
      step();
      total++;
      if (frame_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort_novalid edge %0d: got fv=%b want 0", n, frame_valid);
      end
    end
    bits.delete();
    frames.delete();
    load_frame(8'h96, 8'h0F);
    enable = 1;
    for (int n = 0; n <= C0 + 2; n++) begin
      step();
      total++;
      if ({sck, ws, frame_valid, overrun, left_data, right_data} !== {x_sck, x_ws, m_fv, m_ovr, m_l, m_r}) begin
        bad++;
        $display("FAIL abort_rerun edge %0d: got %b%b%b%b %h %h want %b%b%b%b %h %h", n, sck, ws, frame_valid, overrun,
                 left_data, right_data, x_sck, x_ws, m_fv, m_ovr, m_l, m_r);
      end
      if (n == C0 && {frame_valid, left_data, right_data} !== {1'b1, 8'h96, 8'h0F}) begin
        bad++;
        $display("FAIL abort_frame: got fv=%b l=%h r=%h want 1 96 0f", frame_valid, left_data, right_data);
      end
    end
  endtask

  task automatic test_random();
    go_idle();
    for (int i = 0; i < 4; i++) load_frame(W'($urandom), W'($urandom));
    enable = 1;
    for (int n = 0; n <= C0 + 3 * FP + 6; n++) begin
      frame_ready = 1'($urandom_range(0, 1));
      step();
      total++;
      if ({sck, ws, frame_valid, overrun, left_data, right_data} !== {x_sck, x_ws, m_fv, m_ovr, m_l, m_r}) begin
        bad++;
        $display("FAIL random edge %0d: got %b%b%b%b %h %h want %b%b%b%b %h %h", n, sck, ws, frame_valid, overrun,
                 left_data, right_data, x_sck, x_ws, m_fv, m_ovr, m_l, m_r);
      end
    end
  endtask

  task automatic test_midreset();
    logic [W2-1:0] l2, r2;
    go_idle();
    load_frame(W'($urandom) | W'(1), W'($urandom) | W'(1));
    load_frame(W'($urandom), W'($urandom));
    frame_ready = 0;
    enable = 1;
    repeat (110) step();
    total++;
    if (frame_valid !== 1'b1 || ws !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre: got fv=%b ws=%b want 1 1", frame_valid, ws);
    end
    #3 rst_n = 0;
    #1;
    total++;
    if ({sck, ws, frame_valid, overrun, left_data, right_data} !== '0) begin
      bad++;
      $display("FAIL midreset_async: got %b%b%b%b %h %h want all zero", sck, ws, frame_valid, overrun, left_data, right_data);
    end
    #1 rst_n = 1;
    enable = 0;
    frame_ready = 1;
    e = -1; m_fv = 0; m_ovr = 0; m_l = '0; m_r = '0; x_sck = 0; x_ws = 0;
    bits.delete();
    frames.delete();
    @(posedge clk);
    #1;
    l2 = $urandom;
    r2 = $urandom;
    for (int i = W2 - 1; i >= 0; i--) bits2.push_back(l2[i]);
    for (int i = W2 - 1; i >= 0; i--) bits2.push_back(r2[i]);
    enable2 = 1;
    for (int n = 0; n <= C2 + 1; n++) begin
      @(posedge clk);
      #1;
      if (n == 3 || n == 7 || n == C2 - 1 || n == C2 || n == C2 + 1) total++;
      if ((n == 3 && sck2 !== 1'b1) || (n == 7 && sck2 !== 1'b0)) begin
        bad++;
        $display("FAIL wide_sck edge %0d: got %b", n, sck2);
      end
      if ((n == C2 - 1 && fv2 !== 1'b0) || (n == C2 + 1 && fv2 !== 1'b0) ||
          (n == C2 && {fv2, left2, right2} !== {1'b1, l2, r2})) begin
        bad++;
        $display("FAIL wide_frame edge %0d: got fv=%b l=%h r=%h want l=%h r=%h", n, fv2, left2, right2, l2, r2);
      end
    end
    enable2 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_abort();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
